// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin arbiter and driver sequencer for a shared
// tristate bus. Each requester owns one bufif1 driver bank enabled by its
// registered grant bit; every change of owner is separated by TURN_CYC
// cycles with all drivers released.
//
// Optional macro TRIBUS_HOLD_LIMIT_EN: limits a grant to MAX_HOLD cycles
// while other requesters are waiting. Without it the owner keeps the bus
// until it drops its request.
module tribus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int W        = 8,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W-1:0]         din,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   owner_id,
    output logic                       busy,
    output tri   [W-1:0]               bus
);

    localparam int IDW = $clog2(N_REQ);
    localparam int TCW = $clog2(TURN_CYC + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    // Parameter sanity checks at elaboration
    if (N_REQ < 2)    begin : g_bad_nreq $error("N_REQ must be >= 2");    end
    if (TURN_CYC < 1) begin : g_bad_turn $error("TURN_CYC must be >= 1"); end
    if (MAX_HOLD < 1) begin : g_bad_hold $error("MAX_HOLD must be >= 1"); end

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [TCW-1:0] turn_cnt;
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] ptr_after;
    logic           force_rel;

    // Round-robin pick: first set req bit scanning up from rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!win_found && req[IDW'(j)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(j);
            end
        end
    end

    // Pointer value after the current owner leaves: one past it, wrapping
    always_comb begin
        if (int'(owner_id) == N_REQ - 1) ptr_after = '0;
        else                             ptr_after = owner_id + 1'b1;
    end

`ifdef TRIBUS_HOLD_LIMIT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);
    logic [HCW-1:0] hold_cnt;
    logic           others_req;

    // Release is forced only once the limit is reached and someone else waits
    always_comb begin
        others_req = |(req & ~gnt);
        force_rel  = (state == ST_GRANT) && (hold_cnt == HCW'(MAX_HOLD)) && others_req;
    end

    // Hold counter: 1 on the first owner cycle, saturates at MAX_HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if ((state == ST_IDLE || (state == ST_TURN && turn_cnt <= TCW'(1))) && win_found) begin
            hold_cnt <= HCW'(1);
        end else if (state == ST_GRANT) begin
            if (!req[owner_id] || force_rel) hold_cnt <= '0;
            else if (hold_cnt != HCW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    // No hold limit: the owner keeps the bus until its request drops
    always_comb force_rel = 1'b0;
`endif

    // Main sequencer: IDLE -> GRANT -> TURN -> (GRANT | IDLE)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            turn_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state    <= ST_GRANT;
                        gnt      <= ONE_HOT0 << win_idx;
                        owner_id <= win_idx;
                    end
                end
                ST_GRANT: begin
                    if (!req[owner_id] || force_rel) begin
                        state    <= ST_TURN;
                        gnt      <= '0;
                        owner_id <= '0;
                        rr_ptr   <= ptr_after;
                        turn_cnt <= TCW'(TURN_CYC);
                    end
                end
                ST_TURN: begin
                    if (turn_cnt <= TCW'(1)) begin
                        // Last gap cycle: arbitrate exactly as from IDLE
                        turn_cnt <= '0;
                        if (win_found) begin
                            state    <= ST_GRANT;
                            gnt      <= ONE_HOT0 << win_idx;
                            owner_id <= win_idx;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    gnt      <= '0;
                    owner_id <= '0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // One bufif1 bank per requester; registered one-hot gnt keeps enables exclusive
    for (genvar i = 0; i < N_REQ; i++) begin : g_drv
        for (genvar b = 0; b < W; b++) begin : g_bit
            bufif1 u_drv (bus[b], din[i*W+b], gnt[i]);
        end
    end

endmodule

// File: tb/tb_tribus_arbiter.sv
// tb_tribus_arbiter: table-driven vectors, hand sequences for reset and
// hold behaviour, and randomized traffic checked against a cycle model.
// The bus net is pulled low here, so an undriven bus reads as zero.
module tb_tribus_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TC = 1;
    localparam int MH = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [1:0]     owner_id;
    logic           busy;
    tri0  [W-1:0]   bus;

    tribus_arbiter #(.N_REQ(N), .W(W), .TURN_CYC(TC), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt), .owner_id(owner_id), .busy(busy), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: owner index (-1 none), pointer, gap left, hold length
    int m_owner, m_ptr, m_gap, m_hold;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_gap = 0; m_hold = 0;
    endtask

    // Advance the model by one clock edge using the req seen at that edge
    task automatic model_step();
        bit leave;
        if (m_owner >= 0) begin
            leave = !req[m_owner];
`ifdef TRIBUS_HOLD_LIMIT_EN
            if (m_hold == MH && (req & ~(4'b0001 << m_owner)) != 0) leave = 1;
`endif
            if (leave) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = TC;
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && req[idx]) begin
                    m_owner = idx;
                    m_hold  = 1;
                end
            end
        end
    endtask

    task automatic chk_model(input string tag);
        logic [N-1:0] eg;
        logic [W-1:0] eb;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        eb = (m_owner >= 0) ? din[m_owner*W +: W] : 8'h00;
        chk({tag, ".gnt"},   32'(gnt), 32'(eg));
        chk({tag, ".id"},    32'(owner_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk({tag, ".busy"},  32'(busy), 32'((m_owner >= 0) || (m_gap > 0)));
        chk({tag, ".bus"},   32'(bus), 32'(eb));
        chk({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    endtask

    // One clock: model takes the pre-edge inputs, outputs sampled 1ns after
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [1:0]   id;
        logic         busy;
        logic [W-1:0] bus;
    } vec_t;

    vec_t tv[9];

    initial begin
        rst_n = 1'b0;
        req   = '0;
        din   = 32'h33A52211;
        model_reset();

        // Async reset state before any clock edge
        #2;
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.id", 32'(owner_id), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.bus", 32'(bus), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors; each row applies req then checks after the edge
        tv[0] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA5};
        tv[1] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA5};
        tv[2] = '{4'b0000, 4'b0000, 2'd0, 1'b1, 8'h00};
        tv[3] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00};
        tv[4] = '{4'b1010, 4'b1000, 2'd3, 1'b1, 8'h33};
        tv[5] = '{4'b0010, 4'b0000, 2'd0, 1'b1, 8'h00};
        tv[6] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 8'h22};
        tv[7] = '{4'b0001, 4'b0000, 2'd0, 1'b1, 8'h00};
        tv[8] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 8'h11};
        for (int i = 0; i < 9; i++) begin
            req = tv[i].req;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(tv[i].gnt));
            chk($sformatf("vec%0d.id", i), 32'(owner_id), 32'(tv[i].id));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tv[i].busy));
            chk($sformatf("vec%0d.bus", i), 32'(bus), 32'(tv[i].bus));
        end
        // din changes reach the bus without a clock edge
        din[7:0] = 8'h5C;
        #1;
        chk("din_pass.bus", 32'(bus), 32'h5C);

`ifdef TRIBUS_HOLD_LIMIT_EN
        // All requesting: grants rotate every MAX_HOLD cycles with a 1-cycle gap
        do_reset();
        din = 32'h44332211;
        req = 4'b1111;
        for (int c = 0; c < 5 * (MH + TC) + 2; c++) begin
            cycle();
            chk_model("rot");
        end
`else
        // Without the limit, the lowest-priority waiter never gets the bus
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 100; c++) begin
            cycle();
            chk("hold_forever.gnt", 32'(gnt), 32'b0001);
        end
`endif

        // Lone requester keeps the bus indefinitely
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 50; c++) begin
            cycle();
            chk("lone.gnt", 32'(gnt), 32'b0010);
        end

        // Reset pulse mid-grant clears outputs without a clock edge
        do_reset();
        din = 32'h99887766;
        req = 4'b1000;
        cycle();
        chk("pre_rst.gnt", 32'(gnt), 32'b1000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.gnt", 32'(gnt), 32'd0);
        chk("mid_rst.bus", 32'(bus), 32'd0);
        chk("mid_rst.busy", 32'(busy), 32'd0);
        chk("mid_rst.id", 32'(owner_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        req = 4'b1001;
        cycle();
        chk("post_rst.gnt", 32'(gnt), 32'b0001);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            din = $urandom;
            cycle();
            chk_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
